// File: rtl/merge_pass_engine.sv
// One bottom-up merge pass: streams pairs of presorted runs from a source bank,
// merges them (stable, asc/desc) and writes the merged stream to a destination bank.
module merge_pass_engine #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned KEY_W  = 64,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_in,
  input  logic [ADDR_W:0]   len_in,
  input  logic [ADDR_W:0]   run_len_in,
  input  logic              desc_in,
  output logic              rd_en_out,
  output logic [ADDR_W-1:0] rd_addr_out,
  input  logic [DATA_W-1:0] rd_data_in,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [DATA_W-1:0] wr_data_out,
  input  logic              wr_ready_in,
  output logic              busy_out,
  output logic              done_out
);

  localparam int unsigned CW = ADDR_W + 1;
  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e            state_q;
  cnt_t              len_q, run_q, base_q, a_head_q, b_head_q;
  logic              desc_q;
  logic              rd_en_q, rd_sel_q, resp_q, resp_sel_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              a_vld_q, b_vld_q;
  logic [DATA_W-1:0] a_hold_q, b_hold_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q, wr_idx_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              busy_q, done_q;

  // Saturating add against the stream length; one extra bit so the sum never wraps.
  function automatic cnt_t sat_add(cnt_t x, cnt_t y, cnt_t lim);
    logic [CW:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= {1'b0, lim}) ? lim : s[CW-1:0];
  endfunction

  cnt_t run_eff, start_b_head, a_end, b_end, next_b_head;
  logic a_fly, b_fly, a_exh, b_exh, a_fin, b_fin;
  logic running, rd_a, rd_b, out_free, a_wins, emit_a, emit_b, pair_done;
  logic [KEY_W-1:0] key_a, key_b;

  always_comb begin
    run_eff      = (run_len_in == '0) ? cnt_t'(1) : run_len_in;
    start_b_head = sat_add('0, run_eff, len_in);
    a_end        = sat_add(base_q, run_q, len_q);
    b_end        = sat_add(a_end, run_q, len_q);
    next_b_head  = sat_add(b_end, run_q, len_q);

    // A run has a read in flight from request cycle until its data lands in the hold.
    a_fly = (rd_en_q && !rd_sel_q) || (resp_q && !resp_sel_q);
    b_fly = (rd_en_q && rd_sel_q) || (resp_q && resp_sel_q);
    a_exh = a_head_q >= a_end;
    b_exh = b_head_q >= b_end;
    a_fin = a_exh && !a_fly && !a_vld_q;
    b_fin = b_exh && !b_fly && !b_vld_q;

    running = (state_q == StRun);
    rd_a    = running && !a_vld_q && !a_exh && !a_fly;
    rd_b    = running && !rd_a && !b_vld_q && !b_exh && !b_fly;

    out_free = !wr_en_q || wr_ready_in;
    key_a    = a_hold_q[DATA_W-1 -: KEY_W];
    key_b    = b_hold_q[DATA_W-1 -: KEY_W];
    a_wins   = desc_q ? (key_a >= key_b) : (key_a <= key_b);
    emit_a   = running && out_free && a_vld_q && (b_vld_q ? a_wins : b_fin);
    emit_b   = running && out_free && b_vld_q && (a_vld_q ? !a_wins : a_fin);
    pair_done = running && a_fin && b_fin;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      run_q      <= '0;
      base_q     <= '0;
      a_head_q   <= '0;
      b_head_q   <= '0;
      desc_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_addr_q  <= '0;
      resp_q     <= 1'b0;
      resp_sel_q <= 1'b0;
      a_vld_q    <= 1'b0;
      b_vld_q    <= 1'b0;
      a_hold_q   <= '0;
      b_hold_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_idx_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_en_q <= rd_a || rd_b;
      if (rd_a || rd_b) begin
        rd_sel_q  <= rd_b;
        rd_addr_q <= rd_a ? a_head_q[ADDR_W-1:0] : b_head_q[ADDR_W-1:0];
      end
      if (rd_a) a_head_q <= a_head_q + cnt_t'(1);
      if (rd_b) b_head_q <= b_head_q + cnt_t'(1);
      resp_q     <= rd_en_q;
      resp_sel_q <= rd_sel_q;

      if (resp_q && !resp_sel_q) begin
        a_hold_q <= rd_data_in;
        a_vld_q  <= 1'b1;
      end else if (emit_a) begin
        a_vld_q <= 1'b0;
      end
      if (resp_q && resp_sel_q) begin
        b_hold_q <= rd_data_in;
        b_vld_q  <= 1'b1;
      end else if (emit_b) begin
        b_vld_q <= 1'b0;
      end

      if (emit_a || emit_b) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= wr_idx_q;
        wr_data_q <= emit_a ? a_hold_q : b_hold_q;
        wr_idx_q  <= wr_idx_q + ADDR_W'(1);
      end else if (wr_en_q && wr_ready_in) begin
        wr_en_q <= 1'b0;
      end

      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_in) begin
            state_q  <= StRun;
            len_q    <= len_in;
            run_q    <= run_eff;
            desc_q   <= desc_in;
            base_q   <= '0;
            a_head_q <= '0;
            b_head_q <= start_b_head;
            wr_idx_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        StRun: begin
          if (pair_done) begin
            base_q   <= b_end;
            a_head_q <= b_end;
            b_head_q <= next_b_head;
            if (b_end >= len_q) state_q <= StFlush;
          end
        end
        StFlush: begin
          if (out_free) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rd_en_out   = rd_en_q;
  assign rd_addr_out = rd_addr_q;
  assign wr_en_out   = wr_en_q;
  assign wr_addr_out = wr_addr_q;
  assign wr_data_out = wr_data_q;
  assign busy_out    = busy_q;
  assign done_out    = done_q;

endmodule

// File: tb/tb_merge_pass_engine.sv
// Scoreboard bench for merge_pass_engine: reference merge fills an expected queue,
// a monitor pops and compares on every accepted write.
module tb_merge_pass_engine;
  localparam int DW = 16;
  localparam int KW = 8;
  localparam int AW = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start_in = 1'b0;
  logic          desc_in = 1'b0;
  logic          wr_ready_in = 1'b1;
  logic [AW:0]   len_in = '0;
  logic [AW:0]   run_len_in = '0;
  logic          rd_en_out, wr_en_out, busy_out, done_out;
  logic [AW-1:0] rd_addr_out, wr_addr_out;
  logic [DW-1:0] rd_data_in, wr_data_out;

  always #5 clock = ~clock;

  merge_pass_engine #(.DATA_W(DW), .KEY_W(KW), .ADDR_W(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .start_in    (start_in),
    .len_in      (len_in),
    .run_len_in  (run_len_in),
    .desc_in     (desc_in),
    .rd_en_out   (rd_en_out),
    .rd_addr_out (rd_addr_out),
    .rd_data_in  (rd_data_in),
    .wr_en_out   (wr_en_out),
    .wr_addr_out (wr_addr_out),
    .wr_data_out (wr_data_out),
    .wr_ready_in (wr_ready_in),
    .busy_out    (busy_out),
    .done_out    (done_out)
  );

  logic [DW-1:0] src [64];
  always @(posedge clock) if (rd_en_out) rd_data_in <= src[rd_addr_out];

  int            n_vec = 0;
  int            n_err = 0;
  int            exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  int            acc_cnt = 0;
  int            cur_len = 0;
  int            stall_at = -1;
  int            stall_cnt = 0;
  bit            rand_ready = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: textbook stable merge of run pairs, addresses in emission order.
  task automatic build_ref(input int len, input int r, input bit desc);
    int rr, w, ae, be, i, j;
    bit ta;
    logic [KW-1:0] ka, kb;
    rr = (r == 0) ? 1 : r;
    w  = 0;
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int b = 0; b < len; b += 2 * rr) begin
      ae = (b + rr < len) ? b + rr : len;
      be = (b + 2 * rr < len) ? b + 2 * rr : len;
      i  = b;
      j  = ae;
      while (i < ae || j < be) begin
        if (i >= ae) ta = 0;
        else if (j >= be) ta = 1;
        else begin
          ka = src[i][DW-1 -: KW];
          kb = src[j][DW-1 -: KW];
          ta = desc ? (ka >= kb) : (ka <= kb);
        end
        if (ta) begin exp_data_q.push_back(src[i]); i++; end
        else    begin exp_data_q.push_back(src[j]); j++; end
        exp_addr_q.push_back(w);
        w++;
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    bit            st_pend;
    int            a;
    logic [DW-1:0] d;
    st_pend = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        st_pend = 0;
      end else begin
        if (st_pend) begin
          check("stall_wr_en", 64'(wr_en_out), 64'(1));
          check("stall_wr_addr", 64'(wr_addr_out), 64'(st_addr));
          check("stall_wr_data", 64'(wr_data_out), 64'(st_data));
        end
        st_pend = 0;
        if (wr_en_out && !wr_ready_in) begin
          st_pend = 1;
          st_addr = wr_addr_out;
          st_data = wr_data_out;
        end
        if (rd_en_out) check("rd_addr_in_range", 64'(int'(rd_addr_out) < cur_len), 64'(1));
        if (wr_en_out && wr_ready_in) begin
          if (exp_addr_q.size() == 0) begin
            check("unexpected_write", 64'(1), 64'(0));
          end else begin
            a = exp_addr_q.pop_front();
            d = exp_data_q.pop_front();
            check("wr_addr", 64'(wr_addr_out), 64'(a));
            check("wr_data", 64'(wr_data_out), 64'(d));
          end
          acc_cnt++;
        end
      end
    end
  end

  // Ready driver: optional random back-pressure plus a one-shot 3-cycle stall.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (stall_at >= 0 && acc_cnt == stall_at) begin
        stall_at  = -1;
        stall_cnt = 3;
      end
      if (stall_cnt > 0) begin
        wr_ready_in = 1'b0;
        stall_cnt--;
      end else begin
        wr_ready_in = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
      end
    end
  end

  task automatic run_pass(input int len, input int r, input bit desc, input bit poke);
    int cyc;
    cur_len = len;
    build_ref(len, r, desc);
    acc_cnt = 0;
    @(posedge clock); #1;
    start_in   = 1'b1;
    len_in     = (AW+1)'(len);
    run_len_in = (AW+1)'(r);
    desc_in    = desc;
    @(posedge clock); #1;
    start_in = 1'b0;
    check("busy_after_start", 64'(busy_out), 64'(1));
    // Scramble inputs: they must already be latched.
    len_in     = (AW+1)'($urandom);
    run_len_in = (AW+1)'($urandom);
    desc_in    = 1'($urandom);
    if (poke) begin
      repeat (2) begin @(posedge clock); #1; end
      start_in = 1'b1;
      @(posedge clock); #1;
      start_in = 1'b0;
    end
    cyc = 0;
    while (!done_out && cyc < 5000) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("done_seen", 64'(done_out), 64'(1));
    if (len == 0) check("len0_done_latency", 64'(cyc), 64'(2));
    @(posedge clock); #1;
    check("done_single_pulse", 64'(done_out), 64'(0));
    check("idle_not_busy", 64'(busy_out), 64'(0));
    check("write_count", 64'(acc_cnt), 64'(len));
    check("scoreboard_drained", 64'(exp_addr_q.size()), 64'(0));
    if (poke) begin
      repeat (10) begin @(posedge clock); #1; end
      check("no_extra_pass_writes", 64'(acc_cnt), 64'(len));
      check("no_extra_pass_busy", 64'(busy_out), 64'(0));
    end
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  task automatic load_keys(input int n, input int k0, input int k1, input int k2, input int k3,
                           input int k4, input int k5, input int k6, input int k7);
    int ks[8];
    ks = '{k0, k1, k2, k3, k4, k5, k6, k7};
    for (int i = 0; i < n; i++) src[i] = {KW'(ks[i]), 8'(i + 8'h10)};
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 64; i++) src[i] = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_rd_en", 64'(rd_en_out), 64'(0));
    check("rst_rd_addr", 64'(rd_addr_out), 64'(0));
    check("rst_wr_en", 64'(wr_en_out), 64'(0));
    check("rst_wr_addr", 64'(wr_addr_out), 64'(0));
    check("rst_wr_data", 64'(wr_data_out), 64'(0));
    check("rst_busy", 64'(busy_out), 64'(0));
    check("rst_done", 64'(done_out), 64'(0));
    reset = 1'b0;

    // Ascending, two runs of 4.
    load_keys(8, 1, 5, 7, 9, 2, 3, 8, 10);
    run_pass(8, 4, 0, 0);
    // Descending with odd tail.
    load_keys(5, 9, 4, 8, 6, 7, 0, 0, 0);
    run_pass(5, 2, 1, 0);
    // Equal keys must keep source order.
    for (int i = 0; i < 4; i++) src[i] = {8'd3, 8'(8'ha + i)};
    run_pass(4, 2, 0, 0);
    run_pass(4, 2, 1, 0);
    // Three-cycle back-pressure mid-pass.
    load_keys(8, 1, 5, 7, 9, 2, 3, 8, 10);
    stall_at = 3;
    run_pass(8, 4, 0, 0);
    // Empty stream, and start pulses while busy.
    run_pass(0, 3, 0, 0);
    for (int i = 0; i < 20; i++) src[i] = DW'($urandom);
    run_pass(20, 3, 0, 1);

    // Reset after the third accepted write.
    for (int i = 0; i < 16; i++) src[i] = DW'($urandom);
    cur_len = 16;
    build_ref(16, 4, 0);
    acc_cnt = 0;
    @(posedge clock); #1;
    start_in = 1'b1; len_in = 16; run_len_in = 4; desc_in = 1'b0;
    @(posedge clock); #1;
    start_in = 1'b0;
    cyc = 0;
    while (acc_cnt < 3 && cyc < 1000) begin @(posedge clock); #1; cyc++; end
    check("reached_write_3", 64'(acc_cnt >= 3), 64'(1));
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort_wr_en", 64'(wr_en_out), 64'(0));
    check("abort_busy", 64'(busy_out), 64'(0));
    check("abort_rd_en", 64'(rd_en_out), 64'(0));
    reset = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (3) begin @(posedge clock); #1; end
    check("abort_stays_idle", 64'(wr_en_out), 64'(0));
    run_pass(16, 4, 1, 0);

    // Random passes, with and without back-pressure; small key range forces ties.
    for (int t = 0; t < 16; t++) begin
      int len, r;
      len = $urandom_range(64);
      r   = $urandom_range(12);
      for (int i = 0; i < 64; i++) src[i] = {KW'($urandom_range(15)), 8'($urandom)};
      rand_ready = (t % 2) == 1;
      run_pass(len, r, 1'($urandom), 0);
    end
    rand_ready = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
